// File: rtl/hpdcache_wrr_sched_pkg.sv
// Shared definitions for the weighted round-robin packet scheduler.
package hpdcache_wrr_sched_pkg;

  localparam int unsigned HPDCACHE_WRR_DEFAULT_W = 3;

  // Index width for an N-way selection; a single requester still needs one bit.
  function automatic int unsigned wrr_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Fixed-priority encoder: keeps only the lowest-index set bit of val_i.
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] val_i,
  output logic [N-1:0] val_o
);

  assign val_o = val_i & ~(val_i - N'(1));

endmodule

// File: rtl/hpdcache_wrr_sched_pick.sv
// Rotating-priority picker: first requester at or after start_i, wrapping to index 0.
module hpdcache_wrr_pick
  import hpdcache_wrr_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = wrr_idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] mask;
  logic [N-1:0] req_masked;
  logic [N-1:0] gnt_masked;
  logic [N-1:0] gnt_unmasked;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(start_i));
    end
  end

  assign req_masked = req_i & mask;

  // The masked half covers start..N-1; the unmasked half supplies the wrap-around.
  hpdcache_prio_1hot_encoder #(
    .N (N)
  ) i_enc_masked (
    .val_i (req_masked),
    .val_o (gnt_masked)
  );

  hpdcache_prio_1hot_encoder #(
    .N (N)
  ) i_enc_unmasked (
    .val_i (req_i),
    .val_o (gnt_unmasked)
  );

  assign gnt_o = (|req_masked) ? gnt_masked : gnt_unmasked;

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_o[i]) idx_o = idx_o | IW'(i);
    end
  end

endmodule

// File: rtl/hpdcache_wrr_sched.sv
// Weighted round-robin packet scheduler: grants lock for a whole packet and a
// requester may keep the resource for up to weight consecutive packets.
module hpdcache_wrr_sched
  import hpdcache_wrr_sched_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = HPDCACHE_WRR_DEFAULT_W,
  localparam int unsigned IW = wrr_idx_width(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   last_i,
  input  logic [N*W-1:0] weight_i,
  output logic [N-1:0]   gnt_o,
  output logic [IW-1:0]  gnt_idx_o,
  output logic           valid_o,
  input  logic           ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } hpdcache_wrr_state_e;

  hpdcache_wrr_state_e state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [W-1:0]        credit_q, credit_d;

  logic [IW-1:0] start_ptr;
  logic [N-1:0]  pick_1hot;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  owner_1hot;
  logic          any_req;
  logic          sticky;
  logic [IW-1:0] winner;
  logic [N-1:0]  winner_1hot;
  logic [W-1:0]  weight_a [N];
  logic [W-1:0]  load_val;
  logic [W-1:0]  credit_base;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          valid;
  logic          acc;
  logic          pend;

  assign any_req    = |req_i;
  assign owner_1hot = N'(1) << owner_q;
  assign start_ptr  = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

  hpdcache_wrr_pick #(
    .N  (N),
    .IW (IW)
  ) i_pick (
    .req_i   (req_i),
    .start_i (start_ptr),
    .gnt_o   (pick_1hot),
    .idx_o   (pick_idx)
  );

  // A non-sticky win always differs from owner_q or finds credit exhausted,
  // so !sticky alone decides whether the quota is reloaded.
  assign sticky      = (credit_q != '0) && req_i[owner_q];
  assign winner      = sticky ? owner_q : pick_idx;
  assign winner_1hot = sticky ? owner_1hot : pick_1hot;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      weight_a[k] = weight_i[k*W +: W];
    end
  end

  assign load_val = (weight_a[winner] == '0) ? W'(1) : weight_a[winner];

  always_comb begin
    gnt     = owner_1hot;
    gnt_idx = owner_q;
    if (state_q == ST_IDLE) begin
      gnt     = any_req ? winner_1hot : '0;
      gnt_idx = any_req ? winner : owner_q;
    end
  end

  assign valid = |(gnt & req_i);
  assign acc   = valid & ready_i;
  assign pend  = acc & (|(gnt & last_i));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    credit_base = credit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          if (!sticky) credit_base = load_val;
          if (!acc)      state_d = ST_WAIT;
          else if (pend) state_d = ST_IDLE;
          else           state_d = ST_BURST;
        end
      end
      ST_WAIT: begin
        if (acc) state_d = pend ? ST_IDLE : ST_BURST;
      end
      ST_BURST: begin
        if (pend) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    credit_d = (pend && (credit_base != '0)) ? credit_base - W'(1) : credit_base;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= IW'(N - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o     = gnt;
  assign gnt_idx_o = gnt_idx;
  assign valid_o   = valid;

`ifndef HPDCACHE_ASSERT_OFF
  gnt_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));

  gnt_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != ST_IDLE) |-> $stable(gnt_o));

  owner_req_held_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != ST_IDLE) |-> req_i[owner_q]);
`endif

endmodule

// File: tb/tb_hpdcache_wrr_sched.sv
// Directed and randomized checks of hpdcache_wrr_sched against a packet-level model.
module tb_hpdcache_wrr_sched;

  localparam int unsigned N = 4;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic [W-1:0] wt [N];
  logic [N*W-1:0] weight;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         valid;
  logic         ready;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] og;

  // Packet-level model: who holds the resource, whether a packet is in flight,
  // and how many more packets the holder may still send.
  int m_owner;
  int m_quota;
  bit m_lock;

  always #5 clk = ~clk;

  assign weight = {wt[3], wt[2], wt[1], wt[0]};

  hpdcache_wrr_sched #(
    .N (N),
    .W (W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .last_i    (last),
    .weight_i  (weight),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (valid),
    .ready_i   (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_owner = N - 1;
    m_quota = 0;
    m_lock  = 0;
  endfunction

  function automatic int m_winner();
    if (m_lock) return m_owner;
    if (m_quota > 0 && req[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_owner + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic void m_commit();
    int w;
    int q;
    w = m_winner();
    if (w < 0) return;
    if (!m_lock) begin
      if (w != m_owner || m_quota == 0) begin
        q = int'(wt[w]);
        m_quota = (q == 0) ? 1 : q;
      end
      m_owner = w;
      m_lock  = 1;
    end
    if (req[w] && ready && last[w]) begin
      m_lock = 0;
      if (m_quota > 0) m_quota--;
    end
  endfunction

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    int w;
    logic [N-1:0] eg;
    logic [1:0]   ei;
    logic         ev;
    @(negedge clk);
    req = r; last = l; ready = rdy;
    #1;
    w = m_winner();
    if (w < 0) begin
      eg = '0; ei = 2'(m_owner); ev = 1'b0;
    end else begin
      eg = N'(1) << w; ei = 2'(w); ev = req[w];
    end
    og = gnt;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_idx", 32'(gnt_idx), 32'(ei));
    chk("valid", 32'(valid), 32'(ev));
    @(posedge clk);
    m_commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; last = '0; ready = 1'b0;
    #1;
    m_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'(N - 1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] exp2 [8];
    logic [N-1:0] r;
    logic [N-1:0] l;
    logic         rdy;

    rst_n = 1'b0; req = '0; last = '0; ready = 1'b0;
    for (int i = 0; i < N; i++) wt[i] = 3'd1;
    m_reset();

    // Alternating pair, single-beat packets, unit weights.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 4'b1111, 1'b1);
      chk("alt_seq", 32'(og), (i % 2 == 0) ? 32'h1 : 32'h4);
    end

    // Weight 3 on requester 0.
    do_reset();
    wt[0] = 3'd3;
    exp2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      step(4'b0011, 4'b1111, 1'b1);
      chk("wrr_seq", 32'(og), 32'(exp2[i]));
    end
    wt[0] = 3'd1;

    // Four-beat packet from requester 2 is not interrupted by requester 1.
    do_reset();
    step(4'b0100, 4'b0000, 1'b1); chk("burst_b1", 32'(og), 32'h4);
    step(4'b0110, 4'b0000, 1'b1); chk("burst_b2", 32'(og), 32'h4);
    step(4'b0110, 4'b0000, 1'b1); chk("burst_b3", 32'(og), 32'h4);
    step(4'b0110, 4'b0100, 1'b1); chk("burst_b4", 32'(og), 32'h4);
    step(4'b0110, 4'b0000, 1'b1); chk("burst_next", 32'(og), 32'h2);

    // Grant held while the resource stalls.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 4'b1000, 1'b0); chk("wait_hold", 32'(og), 32'h8);
    end
    step(4'b1001, 4'b1001, 1'b0); chk("wait_newreq", 32'(og), 32'h8);
    step(4'b1001, 4'b1001, 1'b1); chk("wait_accept", 32'(og), 32'h8);
    step(4'b1001, 4'b1001, 1'b1); chk("wait_rotate", 32'(og), 32'h1);

    // Zero weight behaves as one.
    do_reset();
    wt[1] = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 4'b0010, 1'b1);
      chk("w0_gnt", 32'(og), 32'h2);
      #1;
      chk("w0_credit_le1", 32'(dut.credit_q <= 3'd1), 32'h1);
    end
    wt[1] = 3'd1;

    // Asynchronous reset in the middle of a packet.
    do_reset();
    step(4'b0001, 4'b0000, 1'b1); chk("mid_b1", 32'(og), 32'h1);
    @(negedge clk);
    req = 4'b0001; last = '0; ready = 1'b1;
    #1;
    chk("mid_b2", 32'(gnt), 32'h1);
    #1;
    rst_n = 1'b0; req = '0;
    #1;
    m_reset();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_idx", 32'(gnt_idx), 32'h3);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 4'b0001, 1'b1); chk("post_rst", 32'(og), 32'h1);

    // Randomized traffic; the current owner keeps requesting until its packet ends.
    for (int c = 0; c < 600; c++) begin
      if (c % 32 == 0) begin
        for (int i = 0; i < N; i++) wt[i] = W'($urandom_range(0, 7));
      end
      r = N'($urandom_range(0, 15));
      if (m_lock) r[m_owner] = 1'b1;
      l = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      step(r, l, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
